// File: rtl/motion_pkg.sv
// Shared frame geometry, coordinate widths and arbiter state encoding for the motion display path.
package motion_pkg;
  localparam int IMAGE_W = 320;
  localparam int IMAGE_H = 240;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;
endpackage

// File: rtl/plot_arbiter_mark_box_gen.sv
// Marker box address generator: latches the origin on start, then walks the box row-major one pixel per step.
// Outputs are registered-state sums (one bit wider than the coordinates) so off-screen pixels can be detected.
module mark_box_gen
  import motion_pkg::*;
#(
  parameter int MARK_SIZE = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         step,
  input  point_t       origin,
  output logic [X_W:0] x,
  output logic [Y_W:0] y,
  output logic         last
);
  localparam int CW = 3;
  localparam logic [CW-1:0] C_MAX = CW'(MARK_SIZE - 1);

  point_t        org_q, org_d;
  logic [CW-1:0] cx_q, cx_d;
  logic [CW-1:0] cy_q, cy_d;

  always_comb begin
    org_d = org_q;
    cx_d  = cx_q;
    cy_d  = cy_q;
    if (start) begin
      org_d = origin;
      cx_d  = '0;
      cy_d  = '0;
    end else if (step) begin
      if (cx_q == C_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == C_MAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      org_q <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else begin
      org_q <= org_d;
      cx_q  <= cx_d;
      cy_q  <= cy_d;
    end
  end

  assign x    = {1'b0, org_q.x} + (X_W+1)'(cx_q);
  assign y    = {1'b0, org_q.y} + (Y_W+1)'(cy_q);
  assign last = (cx_q == C_MAX) && (cy_q == C_MAX);
endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates scan pixels and marker-box bursts onto one VGA write port; 1-cycle registered plot latency.
// Scan is stalled (scan_ready=0) while a burst runs; after each burst a pending scan wins once (fairness).
module plot_arbiter #(
  parameter int IMAGE_W   = motion_pkg::IMAGE_W,
  parameter int IMAGE_H   = motion_pkg::IMAGE_H,
  parameter int MARK_SIZE = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       scan_valid,
  input  logic [motion_pkg::X_W-1:0] scan_x,
  input  logic [motion_pkg::Y_W-1:0] scan_y,
  input  logic                       scan_colour,
  output logic                       scan_ready,
  input  logic                       mark_req,
  input  logic [motion_pkg::X_W-1:0] mark_x,
  input  logic [motion_pkg::Y_W-1:0] mark_y,
  output logic                       mark_busy,
  output logic                       mark_done,
  output logic                       vga_plot,
  output logic [motion_pkg::X_W-1:0] vga_x,
  output logic [motion_pkg::Y_W-1:0] vga_y,
  output logic                       vga_colour
);
  import motion_pkg::*;

  localparam logic [X_W:0] W_LIM = (X_W+1)'(IMAGE_W);
  localparam logic [Y_W:0] H_LIM = (Y_W+1)'(IMAGE_H);

  state_t         state_q, state_d;
  logic           fair_q, fair_d;
  logic           plot_q, plot_d;
  logic [X_W-1:0] vx_q, vx_d;
  logic [Y_W-1:0] vy_q, vy_d;
  logic           vc_q, vc_d;

  logic           mark_take, gen_start, gen_step, gen_last;
  logic [X_W:0]   gen_x;
  logic [Y_W:0]   gen_y;
  logic           scan_on, box_on;

  mark_box_gen #(.MARK_SIZE(MARK_SIZE)) u_box (
    .clock  (clock),
    .reset  (reset),
    .start  (gen_start),
    .step   (gen_step),
    .origin ('{x: mark_x, y: mark_y}),
    .x      (gen_x),
    .y      (gen_y),
    .last   (gen_last)
  );

  assign scan_on = ({1'b0, scan_x} < W_LIM) && ({1'b0, scan_y} < H_LIM);
  assign box_on  = (gen_x < W_LIM) && (gen_y < H_LIM);

  always_comb begin
    state_d   = state_q;
    fair_d    = fair_q;
    plot_d    = 1'b0;
    vx_d      = vx_q;
    vy_d      = vy_q;
    vc_d      = vc_q;
    gen_start = 1'b0;
    gen_step  = 1'b0;
    mark_take  = (state_q == ST_IDLE) && mark_req && !(fair_q && scan_valid);
    scan_ready = !reset && (state_q == ST_IDLE) && !mark_take;
    mark_busy  = !reset && (state_q != ST_IDLE);
    mark_done  = !reset && (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (mark_take) begin
          gen_start = 1'b1;
          state_d   = ST_MARK;
        end else if (scan_valid) begin
          fair_d = 1'b0;
          // Off-screen scan pixels are consumed but never written.
          if (scan_on) begin
            plot_d = 1'b1;
            vx_d   = scan_x;
            vy_d   = scan_y;
            vc_d   = scan_colour;
          end
        end
      end
      ST_MARK: begin
        gen_step = 1'b1;
        if (box_on) begin
          plot_d = 1'b1;
          vx_d   = gen_x[X_W-1:0];
          vy_d   = gen_y[Y_W-1:0];
          vc_d   = 1'b1;
        end
        if (gen_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        fair_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fair_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fair_q  <= fair_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
    end
  end

  assign vga_plot   = plot_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: vector table, hand-written burst scenarios and randomized traffic against a pixel-queue model.
module tb_plot_arbiter;
  localparam int MS = 5;
  localparam int W  = 320;
  localparam int H  = 240;

  logic       clock = 1'b0;
  logic       reset, scan_valid, scan_colour, scan_ready;
  logic [8:0] scan_x, mark_x, vga_x;
  logic [7:0] scan_y, mark_y, vga_y;
  logic       mark_req, mark_busy, mark_done, vga_plot, vga_colour;

  plot_arbiter #(.IMAGE_W(W), .IMAGE_H(H), .MARK_SIZE(MS)) dut (
    .clock(clock), .reset(reset),
    .scan_valid(scan_valid), .scan_x(scan_x), .scan_y(scan_y), .scan_colour(scan_colour),
    .scan_ready(scan_ready),
    .mark_req(mark_req), .mark_x(mark_x), .mark_y(mark_y),
    .mark_busy(mark_busy), .mark_done(mark_done),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: pending marker pixels as a queue, plus a done flag and fairness bit.
  int qx[$];
  int qy[$];
  bit m_done_now = 0;
  bit m_fair = 0;
  int e_x = 0, e_y = 0, e_c = 0;

  bit last_ready;
  int obs_plots, obs_done, obs_busy, obs_busy_ready;
  int first_x, first_y, last_x, last_y;

  typedef struct {
    bit sv; int sx; int sy; bit sc;
    bit exp_ready; bit exp_plot; int exp_x; int exp_y; int exp_c;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  task automatic clear_obs();
    obs_plots = 0; obs_done = 0; obs_busy = 0; obs_busy_ready = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
  endtask

  // Entered and left at posedge+1; drives one cycle of inputs and checks every output.
  task automatic cycle(input bit rst, input bit sv, input int sx, input int sy, input bit sc,
                       input bit mr, input int mx, input int my);
    bit r_ready, r_busy, r_done, n_plot;
    int nx, ny, nc, px, py;
    reset = rst; scan_valid = sv; scan_x = 9'(sx); scan_y = 8'(sy); scan_colour = sc;
    mark_req = mr; mark_x = 9'(mx); mark_y = 8'(my);
    #3;
    r_ready = 0; r_busy = 0; r_done = 0; n_plot = 0;
    nx = e_x; ny = e_y; nc = e_c;
    if (rst) begin
      qx.delete(); qy.delete();
      m_done_now = 0; m_fair = 0;
      nx = 0; ny = 0; nc = 0;
    end else if (qx.size() > 0) begin
      r_busy = 1;
      px = qx.pop_front(); py = qy.pop_front();
      if (on_screen(px, py)) begin
        n_plot = 1; nx = px; ny = py; nc = 1;
      end
      if (qx.size() == 0) m_done_now = 1;
    end else if (m_done_now) begin
      r_busy = 1; r_done = 1; m_fair = 1; m_done_now = 0;
    end else if (mr && !(m_fair && sv)) begin
      for (int r = 0; r < MS; r++)
        for (int c = 0; c < MS; c++) begin
          qx.push_back(mx + c);
          qy.push_back(my + r);
        end
    end else begin
      r_ready = 1;
      if (sv) begin
        m_fair = 0;
        if (on_screen(sx, sy)) begin
          n_plot = 1; nx = sx; ny = sy; nc = sc;
        end
      end
    end
    last_ready = scan_ready;
    chk("scan_ready", scan_ready, r_ready);
    chk("mark_busy", mark_busy, r_busy);
    chk("mark_done", mark_done, r_done);
    if (mark_done === 1'b1) obs_done++;
    if (mark_busy === 1'b1) obs_busy++;
    if (mark_busy === 1'b1 && scan_ready === 1'b1) obs_busy_ready++;
    @(posedge clock); #1;
    e_x = nx; e_y = ny; e_c = nc;
    chk("vga_plot", vga_plot, n_plot);
    chk("vga_x", vga_x, nx);
    chk("vga_y", vga_y, ny);
    chk("vga_colour", vga_colour, nc);
    if (vga_plot === 1'b1) begin
      if (obs_plots == 0) begin first_x = vga_x; first_y = vga_y; end
      last_x = vga_x; last_y = vga_y;
      obs_plots++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; scan_valid = 0; scan_x = 0; scan_y = 0; scan_colour = 0;
    mark_req = 0; mark_x = 0; mark_y = 0;
    @(posedge clock); #1;

    // Reset state, held for a few cycles with requests active.
    cycle(1, 1, 10, 10, 1, 1, 5, 5);
    cycle(1, 1, 10, 10, 1, 1, 5, 5);
    chk("reset_plot", vga_plot, 0);
    chk("reset_x", vga_x, 0);

    tbl[0] = '{1,  10,  20, 1, 1, 1,  10,  20, 1};
    tbl[1] = '{1, 320,   0, 0, 1, 0,  10,  20, 1};
    tbl[2] = '{1, 319, 239, 0, 1, 1, 319, 239, 0};
    tbl[3] = '{1,   5, 240, 1, 1, 0, 319, 239, 0};
    tbl[4] = '{1, 511, 255, 1, 1, 0, 319, 239, 0};
    tbl[5] = '{0,   7,   7, 1, 1, 0, 319, 239, 0};
    tbl[6] = '{1,   0,   0, 1, 1, 1,   0,   0, 1};
    for (int i = 0; i < 7; i++) begin
      cycle(0, tbl[i].sv, tbl[i].sx, tbl[i].sy, tbl[i].sc, 0, 0, 0);
      chk($sformatf("tbl%0d_ready", i), last_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_plot", i), vga_plot, tbl[i].exp_plot);
      chk($sformatf("tbl%0d_x", i), vga_x, tbl[i].exp_x);
      chk($sformatf("tbl%0d_y", i), vga_y, tbl[i].exp_y);
      chk($sformatf("tbl%0d_c", i), vga_colour, tbl[i].exp_c);
    end

    // Full marker burst at (100,50).
    clear_obs();
    cycle(0, 0, 0, 0, 0, 1, 100, 50);
    idle(28);
    chk("box_plots", obs_plots, 25);
    chk("box_done", obs_done, 1);
    chk("box_busy", obs_busy, 26);
    chk("box_first_x", first_x, 100);
    chk("box_first_y", first_y, 50);
    chk("box_last_x", last_x, 104);
    chk("box_last_y", last_y, 54);

    // Contention: clear fairness with one scan, then hold both requests.
    cycle(0, 1, 1, 1, 0, 0, 0, 0);
    clear_obs();
    for (int i = 0; i < 27; i++) cycle(0, 1, 7, 7, 0, 1, 10, 10);
    chk("cont_busy", obs_busy, 26);
    chk("cont_ready_in_burst", obs_busy_ready, 0);
    cycle(0, 1, 7, 7, 0, 1, 10, 10);
    chk("cont_scan_wins", last_ready, 1);
    chk("cont_scan_x", vga_x, 7);
    cycle(0, 1, 8, 8, 0, 1, 10, 10);
    chk("cont_mark_next", last_ready, 0);
    idle(28);

    // Marker at the bottom-right corner is clipped to 4 pixels.
    clear_obs();
    cycle(0, 0, 0, 0, 0, 1, 318, 238);
    idle(28);
    chk("clip_plots", obs_plots, 4);
    chk("clip_busy", obs_busy, 26);
    chk("clip_last_x", last_x, 319);
    chk("clip_last_y", last_y, 239);

    // Reset on the 10th MARK cycle aborts the burst silently.
    clear_obs();
    cycle(0, 0, 0, 0, 0, 1, 100, 50);
    idle(9);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_plot", vga_plot, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_busy", obs_busy, 9);
    idle(30);
    chk("abort_no_done", obs_done, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 400), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 511), $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
